// File: rtl/jt49_mix_pkg.sv
// Shared types and constants for the jt49 output mixer.
//   state_t    : mixer sequencer states (IDLE..OUT)
//   chan_cfg_t : one channel's sample/gain/pan payload as captured at cen
package jt49_mix_pkg;

  localparam int unsigned NCH    = 3;   // channels A, B, C
  localparam int unsigned CHW    = 8;   // linearised channel width
  localparam int unsigned GAINW  = 8;   // gain width
  localparam int unsigned PANW   = 2;   // {left_en, right_en}
  localparam int unsigned PW     = 16;  // product width
  localparam int unsigned PSHIFT = 2;   // product -> accumulator scaling
  localparam int unsigned SW     = PW - PSHIFT;
  localparam int unsigned XSHIFT = 1;   // accumulator -> DC stage scaling
  localparam int unsigned ACCW   = 16;
  localparam int unsigned XW     = 17;
  localparam int unsigned OUTW   = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULA = 3'd1,
    ST_MULB = 3'd2,
    ST_MULC = 3'd3,
    ST_DC   = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [CHW-1:0]   ch;
    logic [GAINW-1:0] gain;
    logic [PANW-1:0]  pan;
  } chan_cfg_t;

endpackage

// File: rtl/jt49_mix_if.sv
// Mixer bus: per-channel inputs, controls and stereo result.
//   master : driven by the PSG/host side (inputs out, results in)
//   slave  : the mixer itself
interface jt49_mix_if;
  import jt49_mix_pkg::*;

  logic             cen;
  logic [CHW-1:0]   A, B, C;
  logic [GAINW-1:0] gainA, gainB, gainC;
  logic [PANW-1:0]  panA, panB, panC;
  logic             dc_en;
  logic [OUTW-1:0]  left, right;
  logic             valid;
  logic             overrun;

  modport master (
    output cen, A, B, C, gainA, gainB, gainC, panA, panB, panC, dc_en,
    input  left, right, valid, overrun
  );

  modport slave (
    input  cen, A, B, C, gainA, gainB, gainC, panA, panB, panC, dc_en,
    output left, right, valid, overrun
  );
endinterface

// File: rtl/jt49_dcrm.sv
// One-side DC-removal integrator.
//   clk, rst_n : clock, async active-low reset
//   step       : advance the running average by one sample
//   en         : 1 = subtract average, 0 = pass-through and clear average
//   x          : non-negative input sample (XW bits)
//   y          : combinational result for the current x and average
module jt49_dcrm
  import jt49_mix_pkg::*;
#(
  parameter int unsigned DCW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            en,
  input  logic [XW-1:0]   x,
  output logic [OUTW-1:0] y
);

  localparam int unsigned AW = XW + DCW;

  logic signed [AW-1:0]   avg_q, avg_d;
  logic signed [AW-1:0]   avg_int, xs, ydiff;
  logic [AW-OUTW-1:0]     unused_ydiff_hi;

  // Leaky average: avg += x - avg/2^DCW; output is the residual x - avg/2^DCW.
  always_comb begin
    avg_int = avg_q >>> DCW;
    xs      = $signed(AW'(x));
    ydiff   = en ? (xs - avg_int) : xs;
    avg_d   = en ? (avg_q + ydiff) : '0;
  end

  // |ydiff| stays within 16-bit signed range, so the top bits are sign copies.
  assign y               = ydiff[OUTW-1:0];
  assign unused_ydiff_hi = ydiff[AW-1:OUTW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q <= '0;
    end else if (step) begin
      avg_q <= avg_d;
    end
  end

endmodule

// File: rtl/jt49_mix.sv
// PSG output mixer: per-channel gain and pan into stereo, optional DC removal.
// One shared multiplier walks A, B, C after each cen pulse; result after 5 clk.
//   clk, rst_n : clock, async active-low reset
//   bus        : jt49_mix_if.slave (cen, channels, gains, pans, dc_en in;
//                left/right/valid/overrun out, all registered)
module jt49_mix
  import jt49_mix_pkg::*;
#(
  parameter int unsigned DCW = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  jt49_mix_if.slave bus
);

  state_t                state_q, state_d;
  chan_cfg_t [NCH-1:0]   snap_q;
  logic                  dcen_q;
  logic [ACCW-1:0]       accl_q, accr_q;
  logic [OUTW-1:0]       left_q, right_q;
  logic                  valid_q, overrun_q;

  logic                  snap_en, mul_en, dc_step, busy;
  logic [1:0]            sel;
  chan_cfg_t             cur;
  logic [PW-1:0]         prod;
  logic [SW-1:0]         scaled;
  logic [PSHIFT-1:0]     unused_prod_lo;
  logic [XW-1:0]         xl, xr;
  logic [OUTW-1:0]       yl, yr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: only IDLE waits; the pass itself is not gated by cen
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.cen) state_d = ST_MULA;
      ST_MULA: state_d = ST_MULB;
      ST_MULB: state_d = ST_MULC;
      ST_MULC: state_d = ST_DC;
      ST_DC:   state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    snap_en = 1'b0;
    mul_en  = 1'b0;
    dc_step = 1'b0;
    busy    = 1'b1;
    sel     = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        snap_en = bus.cen;
      end
      ST_MULA: begin mul_en = 1'b1; sel = 2'd0; end
      ST_MULB: begin mul_en = 1'b1; sel = 2'd1; end
      ST_MULC: begin mul_en = 1'b1; sel = 2'd2; end
      ST_DC:   dc_step = 1'b1;
      default: ;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    cur = snap_q[0];
    case (sel)
      2'd1:    cur = snap_q[1];
      2'd2:    cur = snap_q[2];
      default: cur = snap_q[0];
    endcase
  end

  assign prod           = PW'(cur.ch) * PW'(cur.gain);
  assign scaled         = prod[PW-1:PSHIFT];
  assign unused_prod_lo = prod[PSHIFT-1:0];

  // Input snapshot, so inputs may move freely during the pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      dcen_q <= 1'b0;
    end else if (snap_en) begin
      snap_q[0] <= '{ch: bus.A, gain: bus.gainA, pan: bus.panA};
      snap_q[1] <= '{ch: bus.B, gain: bus.gainB, pan: bus.panB};
      snap_q[2] <= '{ch: bus.C, gain: bus.gainC, pan: bus.panC};
      dcen_q    <= bus.dc_en;
    end
  end

  // Per-side accumulation; 3 * 16256 fits in 16 bits unsigned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accl_q <= '0;
      accr_q <= '0;
    end else if (snap_en) begin
      accl_q <= '0;
      accr_q <= '0;
    end else if (mul_en) begin
      if (cur.pan[1]) accl_q <= accl_q + ACCW'(scaled);
      if (cur.pan[0]) accr_q <= accr_q + ACCW'(scaled);
    end
  end

  assign xl = XW'(accl_q >> XSHIFT);
  assign xr = XW'(accr_q >> XSHIFT);

  jt49_dcrm #(.DCW(DCW)) u_dcrm_l (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (dc_step),
    .en    (dcen_q),
    .x     (xl),
    .y     (yl)
  );

  jt49_dcrm #(.DCW(DCW)) u_dcrm_r (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (dc_step),
    .en    (dcen_q),
    .x     (xr),
    .y     (yr)
  );

  // Result registers: loaded leaving DC, so they are visible with valid in OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= dc_step;
      overrun_q <= bus.cen & busy;
      if (dc_step) begin
        left_q  <= yl;
        right_q <= yr;
      end
    end
  end

  assign bus.left    = left_q;
  assign bus.right   = right_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_jt49_mix.sv
// Self-checking bench for jt49_mix with a plain-arithmetic reference model.
module tb_jt49_mix;

  localparam int DCW_TB = 4;

  logic clk;
  logic rst_n;
  jt49_mix_if bus ();

  jt49_mix #(.DCW(DCW_TB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus values and model state
  logic [7:0] in_ch   [3];
  logic [7:0] in_gain [3];
  logic [1:0] in_pan  [3];
  logic       in_dc;
  int         avg_l, avg_r;

  task automatic apply_inputs();
    bus.A = in_ch[0];   bus.B = in_ch[1];   bus.C = in_ch[2];
    bus.gainA = in_gain[0]; bus.gainB = in_gain[1]; bus.gainC = in_gain[2];
    bus.panA = in_pan[0];   bus.panB = in_pan[1];   bus.panC = in_pan[2];
    bus.dc_en = in_dc;
  endtask

  task automatic set_all(input logic [7:0] a, b, c, ga, gb, gc,
                         input logic [1:0] pa, pb, pc, input logic dc);
    in_ch[0] = a;  in_ch[1] = b;  in_ch[2] = c;
    in_gain[0] = ga; in_gain[1] = gb; in_gain[2] = gc;
    in_pan[0] = pa;  in_pan[1] = pb;  in_pan[2] = pc;
    in_dc = dc;
    apply_inputs();
  endtask

  // Expected stereo sample for the current stimulus; advances the DC averages.
  task automatic model_pass(output int el, output int er);
    int sl, sr, s, xl, xr, ail, air;
    sl = 0; sr = 0;
    for (int i = 0; i < 3; i++) begin
      s = (int'(in_ch[i]) * int'(in_gain[i])) / 4;
      if (in_pan[i][1]) sl += s;
      if (in_pan[i][0]) sr += s;
    end
    xl = sl / 2;
    xr = sr / 2;
    if (in_dc) begin
      ail = avg_l / (1 << DCW_TB);
      air = avg_r / (1 << DCW_TB);
      el = xl - ail;
      er = xr - air;
      avg_l = avg_l + el;
      avg_r = avg_r + er;
    end else begin
      el = xl;
      er = xr;
      avg_l = 0;
      avg_r = 0;
    end
  endtask

  // Pulse cen from IDLE and wait (bounded) for valid; lat counts clocks after cen.
  task automatic do_pass(input bit scramble, output bit got, output int lat);
    bus.cen = 1'b1;
    @(posedge clk); #1;
    bus.cen = 1'b0;
    lat = 1;
    if (scramble) begin
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.C = 8'($urandom);
      bus.gainA = 8'($urandom); bus.panC = 2'($urandom);
      bus.dc_en = 1'($urandom);
    end
    while (bus.valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    got = (bus.valid === 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cen = 1'b0;
    set_all(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    avg_l = 0; avg_r = 0;
    #23;
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd0) begin
      failures++;
      $display("FAIL reset_lr left=%0h right=%0h exp=0", bus.left, bus.right);
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes valid=%b overrun=%b exp=0", bus.valid, bus.overrun);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_unity();
    bit got; int lat, el, er;
    set_all(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
    model_pass(el, er);
    do_pass(1'b0, got, lat);
    checks++;
    if (!got || lat != 5) begin
      failures++;
      $display("FAIL unity_latency got_valid=%0d lat=%0d exp=5", got, lat);
    end
    checks++;
    if (bus.left !== 16'(el) || bus.right !== 16'(er) || el != 8128) begin
      failures++;
      $display("FAIL unity_value left=%0d right=%0d exp=%0d/%0d", bus.left, bus.right, el, er);
    end
    tick(1);
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL unity_valid_width valid=%b exp=0", bus.valid);
    end
    checks++;
    if (bus.left !== 16'd8128 || bus.right !== 16'd8128) begin
      failures++;
      $display("FAIL unity_hold left=%0d right=%0d exp=8128", bus.left, bus.right);
    end
  endtask

  task automatic test_pan();
    bit got; int lat, el, er;
    set_all(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 2'b10, 2'b01, 2'b11, 1'b0);
    model_pass(el, er);
    do_pass(1'b0, got, lat);
    checks++;
    if (!got || bus.left !== 16'd16256 || bus.right !== 16'd16256 ||
        bus.left !== 16'(el) || bus.right !== 16'(er)) begin
      failures++;
      $display("FAIL pan_sum left=%0d right=%0d exp=16256", bus.left, bus.right);
    end
    tick(1);
    in_pan[2] = 2'b00;
    apply_inputs();
    model_pass(el, er);
    do_pass(1'b0, got, lat);
    checks++;
    if (!got || bus.left !== 16'd8128 || bus.right !== 16'd8128 ||
        bus.left !== 16'(el) || bus.right !== 16'(er)) begin
      failures++;
      $display("FAIL pan_c_off left=%0d right=%0d exp=8128", bus.left, bus.right);
    end
    tick(1);
  endtask

  task automatic test_dc_converge();
    bit got; int lat, el, er, cur, prev;
    set_all(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b1);
    prev = 32'h7fffffff;
    for (int n = 1; n <= 200; n++) begin
      model_pass(el, er);
      do_pass(1'b0, got, lat);
      cur = int'($signed(bus.left));
      checks++;
      if (!got || bus.left !== 16'(el) || bus.right !== 16'(er)) begin
        failures++;
        $display("FAIL dc_sample%0d left=%0d right=%0d exp=%0d/%0d", n, cur,
                 $signed(bus.right), el, er);
      end
      if (n == 1) begin
        checks++;
        if (cur != 8128) begin
          failures++;
          $display("FAIL dc_first left=%0d exp=8128", cur);
        end
      end
      if (n == 2) begin
        checks++;
        if (cur != 7620) begin
          failures++;
          $display("FAIL dc_second left=%0d exp=7620", cur);
        end
      end
      checks++;
      if (cur > prev) begin
        failures++;
        $display("FAIL dc_monotonic sample=%0d left=%0d prev=%0d", n, cur, prev);
      end
      prev = cur;
      if (n == 200) begin
        checks++;
        if (cur > 16 || cur < -16) begin
          failures++;
          $display("FAIL dc_settle left=%0d exp=within 16 of 0", cur);
        end
      end
      tick(3);
    end
  endtask

  task automatic test_overrun();
    int el, er, nvalid;
    set_all(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
    model_pass(el, er);
    bus.cen = 1'b1;
    tick(1);                       // cycle 1
    bus.cen = 1'b0;
    tick(1);                       // cycle 2
    bus.cen = 1'b1;
    bus.A = 8'd0;
    tick(1);                       // cycle 3
    bus.cen = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_flag overrun=%b valid=%b exp=1/0", bus.overrun, bus.valid);
    end
    tick(1);                       // cycle 4
    checks++;
    if (bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width overrun=%b exp=0", bus.overrun);
    end
    tick(1);                       // cycle 5
    checks++;
    if (bus.valid !== 1'b1 || bus.left !== 16'(el) || bus.right !== 16'(er)) begin
      failures++;
      $display("FAIL overrun_result valid=%b left=%0d right=%0d exp=1/%0d/%0d",
               bus.valid, bus.left, bus.right, el, er);
    end
    bus.cen = 1'b1;                // cen together with valid
    tick(1);                       // cycle 6
    bus.cen = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_at_valid overrun=%b valid=%b exp=1/0", bus.overrun, bus.valid);
    end
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      failures++;
      $display("FAIL overrun_ignored valids=%0d exp=0", nvalid);
    end
    apply_inputs();
  endtask

  task automatic test_snapshot();
    bit got; int lat, el, er;
    set_all(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
    model_pass(el, er);
    bus.cen = 1'b1;
    tick(1);
    bus.cen = 1'b0;
    bus.A = 8'd0;
    lat = 1;
    while (bus.valid !== 1'b1 && lat < 12) begin tick(1); lat++; end
    got = (bus.valid === 1'b1);
    checks++;
    if (!got || lat != 5 || bus.left !== 16'd8128 || bus.right !== 16'd8128) begin
      failures++;
      $display("FAIL snapshot got=%0d lat=%0d left=%0d right=%0d exp=8128",
               got, lat, bus.left, bus.right);
    end
    tick(1);
    apply_inputs();
  endtask

  task automatic test_reset_midpass();
    bit got, seen; int lat, el, er;
    set_all(8'd200, 8'd100, 8'd50, 8'd255, 8'd128, 8'd64, 2'b11, 2'b10, 2'b01, 1'b0);
    bus.cen = 1'b1;
    tick(1);                       // cycle 1
    bus.cen = 1'b0;
    tick(1);                       // cycle 2
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.left !== 16'd0 || bus.right !== 16'd0 ||
        bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs left=%0d right=%0d valid=%b overrun=%b exp=0",
               bus.left, bus.right, bus.valid, bus.overrun);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1 || bus.overrun === 1'b1) seen = 1'b1;
    end
    rst_n = 1'b1;
    avg_l = 0; avg_r = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.valid === 1'b1 || bus.overrun === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_strobe saw valid/overrun after abort");
    end
    model_pass(el, er);
    do_pass(1'b0, got, lat);
    checks++;
    if (!got || lat != 5 || bus.left !== 16'(el) || bus.right !== 16'(er)) begin
      failures++;
      $display("FAIL midreset_recover got=%0d lat=%0d left=%0d right=%0d exp=%0d/%0d",
               got, lat, bus.left, bus.right, el, er);
    end
    tick(1);
  endtask

  task automatic test_random();
    bit got; int lat, el, er;
    for (int n = 0; n < 40; n++) begin
      set_all(8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom_range(0, 3) != 0));
      model_pass(el, er);
      do_pass(1'b1, got, lat);
      checks++;
      if (!got || lat != 5 || bus.left !== 16'(el) || bus.right !== 16'(er)) begin
        failures++;
        $display("FAIL random%0d got=%0d lat=%0d left=%0d right=%0d exp=%0d/%0d",
                 n, got, lat, $signed(bus.left), $signed(bus.right), el, er);
      end
      tick(1 + $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_pan();
    test_dc_converge();
    test_overrun();
    test_snapshot();
    test_reset_midpass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt49_mix.md
Name: jt49_mix

Overview:
- Output mixing stage fed directly by the PSG core's linearised per-channel outputs A, B and C.
- Applies a per-channel 8-bit gain and per-channel left/right pan to produce signed 16-bit stereo samples.
- Optional DC-removal high-pass per side.
- One time-multiplexed multiplier, sequenced by a small FSM; one result per sample-enable pulse.

Parameters:
DCW, 10, DC-removal integrator shift (cutoff ~ fs/(2*pi*2^DCW)); legal range 2..14.

Ports:
clk      in   1   system clock, rising edge
rst_n    in   1   asynchronous active-low reset
cen      in   1   sample enable; one-cycle pulse starts one mix pass
A        in   8   linearised channel A (unsigned)
B        in   8   linearised channel B
C        in   8   linearised channel C
gainA    in   8   channel A gain, unsigned, 255 ~ unity
gainB    in   8   channel B gain
gainC    in   8   channel C gain
panA     in   2   {left_en,right_en} for A
panB     in   2   {left_en,right_en} for B
panC     in   2   {left_en,right_en} for C
dc_en    in   1   1 = DC removal active, 0 = bypass
left     out  16  signed left sample
right    out  16  signed right sample
valid    out  1   one-cycle strobe, left/right updated this cycle
overrun  out  1   one-cycle strobe: cen arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - left=0, right=0, valid=0, overrun=0.
  - FSM in IDLE; accL=accR=0; avgL=avgR=0.
  - Effective immediately, including mid-pass; an aborted pass never raises valid.
- FSM states: IDLE -> MULA -> MULB -> MULC -> DC -> OUT -> IDLE.
  - IDLE leaves only on cen=1; every other state advances unconditionally each clk.
  - The FSM is not gated by cen.
- IDLE with cen=1 (cycle 0):
  - Snapshot A/B/C, gains, pans and dc_en into internal registers.
  - Clear accL and accR.
  - Inputs may change freely after this cycle without affecting the pass.
- MULx (cycles 1..3), one channel per cycle in the order A, B, C:
  - p = ch*gain, 16-bit unsigned.
  - s = p[15:2], 14 bits.
  - accL += s if left_en; accR += s if right_en.
  - accL/accR are 16-bit unsigned; maximum 3*16256=48768, so no overflow.
- DC (cycle 4), per side:
  - x = acc>>1, treated as 17-bit signed non-negative, range 0..24384.
  - If snapshot dc_en=1:
    - avg_int = avg_full >>> DCW.
    - y = x - avg_int.
    - avg_full <= avg_full + x - avg_int; avg_full is (17+DCW)-bit signed.
  - If snapshot dc_en=0: y = x, and avg_full <= 0.
  - |y| <= 24384 in all cases, so the result fits 16-bit signed without saturation.
- OUT (cycle 5):
  - left/right <= y[15:0], registered.
  - valid=1 for exactly this cycle.
- Latency: cen at cycle 0 -> valid at cycle 5. Minimum cen spacing is 6 clocks.
- cen while not IDLE (cycles 1..5): the pulse is ignored, no snapshot is taken, and overrun=1 in the following cycle.
- cen in the same cycle valid is asserted is also an overrun.
- left/right hold their value between valid strobes.
- dc_en toggling takes effect at the next snapshot. Re-enabling DC removal restarts the average from 0.

Decomposition:
- Package jt49_mix_pkg holds:
  - FSM state encoding (IDLE..OUT, 3-bit);
  - the product shift constant (2) and the pre-DC shift constant (1);
  - widths ACCW=16 and XW=17.
- Sub-module jt49_dcrm: one DC-removal integrator with ports clk, rst_n, step, en, x[16:0], y[15:0]. It is instantiated twice (left, right) and stepped in the DC state.
- The multiplier, accumulators and FSM live in jt49_mix.

Test Plan:
- Scenario 1 (unity, bypass): dc_en=0, A=255, gainA=255, panA=11, B=C=0; pulse cen -> valid at cen+5 with left=right=8128; valid high 1 cycle only.
- Scenario 2 (pan and sum): dc_en=0, A=B=C=255, gains=255, panA=10, panB=01, panC=11 -> left=16256, right=16256. Then panC=00 -> left=right=8128.
- Scenario 3 (DC convergence): DCW=4, dc_en=1, scenario 1 inputs, repeated cen every 8 clocks:
  - 1st sample 8128;
  - 2nd sample 7620;
  - sample 200 is within +-16 of 0 and monotonically non-increasing.
- Scenario 4 (overrun): cen at cycle 0 and cycle 2 -> overrun=1 at cycle 3; exactly one valid at cycle 5; outputs equal the cycle-0 snapshot.
- Scenario 5 (snapshot isolation): change A from 255 to 0 at cycle 1 -> output still 8128.
- Scenario 6 (reset mid-pass): rst_n low at cycle 2 for 3 clocks -> left=right=0, valid never asserted, overrun=0. The next cen after release gives a correct result at +5.
